// File: rtl/rms_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rms_pkg : shared types and sizing helpers for the RMS frame controller   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rms_pkg;

  typedef enum logic [2:0] {
    ACCUM  = 3'd0,
    LAUNCH = 3'd1,
    WAIT1  = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_LOG2N = 2;
  localparam int ACC_W     = 2 * DEF_IN_W + DEF_LOG2N;

  // Sum of 2**log2n squares of in_w-bit signed samples never exceeds this width.
  function automatic int acc_width(input int in_w, input int log2n);
    return 2 * in_w + log2n;
  endfunction

  // Cycles the sibling square-root core stays busy per computation.
  function automatic int root_iter(input int width, input int fbits);
    return (width + fbits) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rms_frame_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rms_frame_ctrl_if : sample, root-core and result handshakes              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rms_frame_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int IN_W  = 16
);

  logic                   s_valid;
  logic                   s_ready;
  logic signed [IN_W-1:0] s_data;

  logic                   sq_start;
  logic [WIDTH-1:0]       sq_rad;
  logic                   sq_busy;
  logic [WIDTH-1:0]       sq_root;

  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH-1:0]       m_rms;

  modport master (
    input  s_valid, s_data, sq_busy, sq_root, m_ready,
    output s_ready, sq_start, sq_rad, m_valid, m_rms
  );

  modport slave (
    output s_valid, s_data, sq_busy, sq_root, m_ready,
    input  s_ready, sq_start, sq_rad, m_valid, m_rms
  );

endinterface
`default_nettype wire

// File: rtl/rms_frame_ctrl_sq_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sq_mac : signed square-and-accumulate with frame sample counter          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sq_mac #(
  parameter int IN_W  = 16,
  parameter int LOG2N = 2,
  parameter int ACC_W = 2 * IN_W + LOG2N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic signed [IN_W-1:0] s_data,
  output logic [ACC_W-1:0]       acc_next,
  output logic                   last
);

  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [LOG2N-1:0]         cnt_q, cnt_d;
  logic signed [2*IN_W-1:0] sq_prod;

  // A square is never negative, so it joins the sum as an unsigned value.
  always_comb begin
    sq_prod  = s_data * s_data;
    acc_next = acc_q + ACC_W'($unsigned(sq_prod));
    last     = &cnt_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en) begin
      acc_d = acc_next;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rms_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rms_frame_ctrl : frame mean-square accumulator feeding a root core       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rms_frame_ctrl
  import rms_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FBITS      = 16,
  parameter int IN_W       = 16,
  parameter int LOG2N      = 2,
  parameter int ROOT_WIDTH = WIDTH,
  parameter int ROOT_FBITS = FBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  rms_frame_ctrl_if.master bus
);

  localparam int ACC_W = acc_width(IN_W, LOG2N);

  if (WIDTH < 2 * IN_W) begin : g_chk_width
    $error("rms_frame_ctrl: WIDTH must be at least 2*IN_W");
  end
  if ((FBITS % 2) != 0) begin : g_chk_fbits
    $error("rms_frame_ctrl: FBITS must be even");
  end
  if ((WIDTH != ROOT_WIDTH) || (FBITS != ROOT_FBITS)) begin : g_chk_core
    $error("rms_frame_ctrl: WIDTH/FBITS must match the root core");
  end
  if ((LOG2N < 1) || (LOG2N > 8)) begin : g_chk_log2n
    $error("rms_frame_ctrl: LOG2N must lie in 1..8");
  end

  state_e           state_q, state_d;
  logic             run_q;
  logic             sq_start_q, sq_start_d;
  logic [WIDTH-1:0] sq_rad_q, sq_rad_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_rms_q, m_rms_d;

  logic             s_ready;
  logic             s_hs;
  logic             mac_en;
  logic             mac_clr;
  logic [ACC_W-1:0] acc_next;
  logic             mac_last;

  // run_q keeps s_ready low for the first cycle after reset release.
  assign s_ready      = run_q && (state_q == ACCUM);
  assign s_hs         = bus.s_valid && s_ready;
  assign bus.s_ready  = s_ready;
  assign bus.sq_start = sq_start_q;
  assign bus.sq_rad   = sq_rad_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_rms    = m_rms_q;

  sq_mac #(
    .IN_W  (IN_W),
    .LOG2N (LOG2N),
    .ACC_W (ACC_W)
  ) u_sq_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mac_en),
    .clr      (mac_clr),
    .s_data   (bus.s_data),
    .acc_next (acc_next),
    .last     (mac_last)
  );

  always_comb begin
    state_d    = state_q;
    sq_start_d = 1'b0;
    sq_rad_d   = sq_rad_q;
    m_valid_d  = m_valid_q;
    m_rms_d    = m_rms_q;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (s_hs) begin
          mac_en = 1'b1;
          if (mac_last) begin
            state_d    = LAUNCH;
            sq_start_d = 1'b1;
            sq_rad_d   = WIDTH'(acc_next >> LOG2N);
          end
        end
      end
      LAUNCH: state_d = WAIT1;
      // The core raises busy on the edge that samples start, so skip one cycle.
      WAIT1:  state_d = WAIT;
      WAIT: begin
        if (!bus.sq_busy) begin
          m_rms_d   = bus.sq_root;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          mac_clr   = 1'b1;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      run_q      <= 1'b0;
      sq_start_q <= 1'b0;
      sq_rad_q   <= '0;
      m_valid_q  <= 1'b0;
      m_rms_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      sq_start_q <= sq_start_d;
      sq_rad_q   <= sq_rad_d;
      m_valid_q  <= m_valid_d;
      m_rms_q    <= m_rms_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rms_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rms_frame_ctrl : bench for rms_frame_ctrl with a behavioural root core|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rms_frame_ctrl;
  import rms_pkg::*;

  localparam int WIDTH = 32;
  localparam int FBITS = 16;
  localparam int IN_W  = 16;
  localparam int LOG2N = 2;
  localparam int N     = 4;
  localparam int LAT   = 26;
  localparam int ITER  = root_iter(WIDTH, FBITS);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rms_frame_ctrl_if #(.WIDTH(WIDTH), .IN_W(IN_W)) bus();

  rms_frame_ctrl #(
    .WIDTH (WIDTH),
    .FBITS (FBITS),
    .IN_W  (IN_W),
    .LOG2N (LOG2N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cnt = 0;
  logic [WIDTH-1:0] rad_at_start = '0;
  logic [IN_W-1:0]  frame_smp [N];

  // Root core stand-in: unreset, busy ITER cycles, bit-serial integer root.
  logic             core_busy = 1'b1;
  int               core_cnt  = 0;
  logic [WIDTH-1:0] core_res  = '0;
  logic [WIDTH-1:0] core_root = 32'hDEAD_BEEF;
  assign bus.sq_busy = core_busy;
  assign bus.sq_root = core_root;

  function automatic logic [31:0] core_isqrt(input longint unsigned v);
    longint unsigned res = 0;
    longint unsigned t;
    for (int b = 31; b >= 0; b--) begin
      t = res | (64'd1 << b);
      if (t * t <= v) res = t;
    end
    return res[31:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.sq_start === 1'b1) begin
      core_busy <= 1'b1;
      core_cnt  <= ITER;
      core_res  <= core_isqrt(64'(bus.sq_rad) << FBITS);
    end else if (core_busy && core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_busy <= 1'b0;
        core_root <= core_res;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.sq_start === 1'b1) begin
      start_cnt    = start_cnt + 1;
      rad_at_start = bus.sq_rad;
    end
  end

  // Reference: mean of squares in Q.FBITS, then floor(sqrt) via real arithmetic.
  function automatic longint model_rad();
    longint s = 0;
    longint v;
    for (int i = 0; i < N; i++) begin
      v = longint'($signed(frame_smp[i]));
      s += v * v;
    end
    return s / N;
  endfunction

  function automatic longint model_rms(input longint rad);
    longint x = rad * 65536;
    longint q = longint'($rtoi($sqrt(real'(x))));
    while (q * q > x) q--;
    while ((q + 1) * (q + 1) <= x) q++;
    return q;
  endfunction

  // mode 0: s_valid every cycle, 1: one cycle in three, 2: random.
  task automatic drive_frame(input int mode, output bit ok, output int last_edge);
    int i = 0;
    int t = 0;
    last_edge = 0;
    while (i < N && t < 300) begin
      @(negedge clk);
      case (mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = ((t % 3) == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      bus.s_data = frame_smp[i];
      if (bus.s_valid && bus.s_ready) begin
        i++;
        last_edge = cyc + 1;
      end
      t++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    ok = (i == N);
  endtask

  task automatic wait_mvalid(output bit ok, output int edge_seen);
    ok = 1'b0;
    edge_seen = 0;
    for (int t = 0; t < 200; t++) begin
      if (bus.m_valid === 1'b1) begin
        ok = 1'b1;
        edge_seen = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_result(input int delay, input bit tied, output bit ok);
    ok = 1'b0;
    repeat (delay) @(negedge clk);
    bus.m_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.m_ready = tied;
  endtask

  task automatic exec_frame(input int mode, input int ready_delay, input bit tied,
                            output bit ok, output int lat, output int starts,
                            output logic [WIDTH-1:0] rms, output logic [WIDTH-1:0] rad);
    bit ok_d, ok_w, ok_r;
    int le, e;
    int st0 = start_cnt;
    bus.m_ready = tied;
    drive_frame(mode, ok_d, le);
    wait_mvalid(ok_w, e);
    rms    = bus.m_rms;
    rad    = rad_at_start;
    starts = start_cnt - st0;
    lat    = e - le;
    release_result(ready_delay, tied, ok_r);
    ok = ok_d && ok_w && ok_r;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks += 5;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
    if (bus.sq_start !== 1'b0) begin failures++; $display("FAIL reset_sq_start: got %b expected 0", bus.sq_start); end
    if (bus.sq_rad !== '0) begin failures++; $display("FAIL reset_sq_rad: got %h expected 0", bus.sq_rad); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    if (bus.m_rms !== '0) begin failures++; $display("FAIL reset_m_rms: got %h expected 0", bus.m_rms); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_cycle_s_ready: got %b expected 0", bus.s_ready); end
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready: got %b expected 1", bus.s_ready); end
  endtask

  task automatic test_directed(input string name, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                               input logic [WIDTH-1:0] exp_rad, input logic [WIDTH-1:0] exp_rms);
    bit ok;
    int lat, starts;
    logic [WIDTH-1:0] rms, rad;
    frame_smp[0] = a; frame_smp[1] = b; frame_smp[2] = a; frame_smp[3] = b;
    exec_frame(0, 2, 1'b0, ok, lat, starts, rms, rad);
    checks += 5;
    if (!ok) begin failures++; $display("FAIL %s_timeout: handshake did not complete", name); end
    if (rad !== exp_rad) begin failures++; $display("FAIL %s_sq_rad: got %h expected %h", name, rad, exp_rad); end
    if (rms !== exp_rms) begin failures++; $display("FAIL %s_m_rms: got %h expected %h", name, rms, exp_rms); end
    if (lat != LAT) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
    if (starts != 1) begin failures++; $display("FAIL %s_starts: got %0d expected 1", name, starts); end
  endtask

  task automatic test_hold_stall();
    bit ok;
    int le, e, st0;
    logic [WIDTH-1:0] held;
    for (int i = 0; i < N; i++) frame_smp[i] = '0;
    bus.m_ready = 1'b0;
    drive_frame(0, ok, le);
    wait_mvalid(ok, e);
    held = bus.m_rms;
    st0  = start_cnt;
    checks += 2;
    if (!ok) begin failures++; $display("FAIL hold_timeout: m_valid never rose"); end
    if (held !== '0) begin failures++; $display("FAIL hold_m_rms: got %h expected 0", held); end
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h7FFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks += 4;
      if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL hold_m_valid c%0d: got %b expected 1", c, bus.m_valid); end
      if (bus.m_rms !== held) begin failures++; $display("FAIL hold_stable c%0d: got %h expected %h", c, bus.m_rms, held); end
      if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL hold_s_ready c%0d: got %b expected 0", c, bus.s_ready); end
      if (bus.sq_start !== 1'b0) begin failures++; $display("FAIL hold_sq_start c%0d: got %b expected 0", c, bus.sq_start); end
    end
    bus.s_valid = 1'b0;
    release_result(0, 1'b0, ok);
    checks += 2;
    if (!ok) begin failures++; $display("FAIL hold_release: m_valid stuck high"); end
    if (start_cnt != st0) begin failures++; $display("FAIL hold_starts: got %0d expected %0d", start_cnt, st0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int le, lat, starts;
    logic [WIDTH-1:0] rms, rad;
    for (int i = 0; i < N; i++) frame_smp[i] = 16'h1234;
    bus.m_ready = 1'b0;
    drive_frame(0, ok, le);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL midrst_s_ready: got %b expected 0", bus.s_ready); end
    if (bus.sq_start !== 1'b0) begin failures++; $display("FAIL midrst_sq_start: got %b expected 0", bus.sq_start); end
    if (bus.sq_rad !== '0) begin failures++; $display("FAIL midrst_sq_rad: got %h expected 0", bus.sq_rad); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid: got %b expected 0", bus.m_valid); end
    if (bus.m_rms !== '0) begin failures++; $display("FAIL midrst_m_rms: got %h expected 0", bus.m_rms); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) frame_smp[i] = 16'h0200;
    exec_frame(0, 1, 1'b0, ok, lat, starts, rms, rad);
    checks += 3;
    if (!ok) begin failures++; $display("FAIL midrst_next_timeout: handshake did not complete"); end
    if (rms !== 32'h0002_0000) begin failures++; $display("FAIL midrst_next_m_rms: got %h expected 00020000", rms); end
    if (starts != 1) begin failures++; $display("FAIL midrst_next_starts: got %0d expected 1", starts); end
  endtask

  task automatic test_random_frames(input string name, input int mode, input int frames, input bit tied);
    bit ok;
    int lat, starts;
    logic [WIDTH-1:0] rms, rad;
    longint erad, erms;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < N; i++) frame_smp[i] = IN_W'($urandom);
      erad = model_rad();
      erms = model_rms(erad);
      exec_frame(mode, tied ? 0 : int'($urandom_range(0, 5)), tied, ok, lat, starts, rms, rad);
      checks += 5;
      if (!ok) begin failures++; $display("FAIL %s_timeout f%0d: handshake did not complete", name, f); end
      if (rad !== WIDTH'(erad)) begin failures++; $display("FAIL %s_sq_rad f%0d: got %h expected %h", name, f, rad, WIDTH'(erad)); end
      if (rms !== WIDTH'(erms)) begin failures++; $display("FAIL %s_m_rms f%0d: got %h expected %h", name, f, rms, WIDTH'(erms)); end
      if (lat != LAT) begin failures++; $display("FAIL %s_latency f%0d: got %0d expected %0d", name, f, lat, LAT); end
      if (starts != 1) begin failures++; $display("FAIL %s_starts f%0d: got %0d expected 1", name, f, starts); end
    end
    bus.m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed("unity", 16'h0100, 16'h0100, 32'h0001_0000, 32'h0001_0000);
    test_directed("alt3",  16'h0300, 16'hFD00, 32'h0009_0000, 32'h0003_0000);
    test_directed("maxmag", 16'h8000, 16'h8000, 32'h4000_0000, 32'h0080_0000);
    test_hold_stall();
    test_reset_mid();
    test_random_frames("gapped", 1, 3, 1'b1);
    test_random_frames("random", 2, 6, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
